// File: rtl/editor_pkg.sv
// rtl/editor_pkg.sv - shared types for the field editor
// Purpose: FSM state encoding, cursor width/limit and the decoded pulse actions
//          used by editor_campos and its field counters.
// Ports:   none (package).
package editor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } estado_t;

  localparam int              CURSOR_W   = 2;
  localparam logic [CURSOR_W-1:0] CURSOR_MAX = 2'd2;

  // One action per cycle in EDIT, already resolved by priority.
  typedef enum logic [2:0] {
    NOP = 3'd0,
    INC = 3'd1,
    DEC = 3'd2,
    DER = 3'd3,
    IZQ = 3'd4,
    ENT = 3'd5
  } accion_t;

endpackage

// File: rtl/contador_mod.sv
// rtl/contador_mod.sv - modulo-(MAX+1) up/down counter with load and clear
// Purpose: holds one edited field; wraps MAX->0 going up and 0->MAX going down.
// Ports:   CLK, reset (sync, active-high), clr (sync clear), load/din (parallel
//          load), inc, dec (single step), q (current value).
// Priority: reset > clr > load > inc > dec.
module contador_mod #(
  parameter int ANCHO = 8,
  parameter int MAX   = 59
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [ANCHO-1:0] din,
  input  logic             inc,
  input  logic             dec,
  output logic [ANCHO-1:0] q
);

  localparam logic [ANCHO-1:0] MAXV = ANCHO'(MAX);

  always_ff @(posedge CLK) begin
    if (reset || clr) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (inc) begin
      q <= (q >= MAXV) ? '0 : q + ANCHO'(1);
    end else if (dec) begin
      q <= (q == '0) ? MAXV : q - ANCHO'(1);
    end
  end

endmodule

// File: rtl/editor_campos.sv
// rtl/editor_campos.sv - three-field editor driven by debounced button pulses
// Purpose: Enter loads the live values and opens an edit session; arrows move the
//          cursor or step the selected field; a second Enter raises escribir for
//          one cycle. Optional idle abort under macro EDITOR_TIMEOUT_EN.
// Ports:   CLK, reset (sync, active-high); p_enter/p_arriba/p_abajo/p_der/p_izq
//          (1-cycle pulses); val0_in..val2_in (live values); campo0..campo2
//          (edited fields); cursor (0..2); editando (in EDIT); escribir (commit).
import editor_pkg::*;

module editor_campos #(
  parameter int ANCHO   = 8,
  parameter int MAX0    = 23,
  parameter int MAX1    = 59,
  parameter int MAX2    = 59,
  parameter int TIMEOUT = 1000
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                p_enter,
  input  logic                p_arriba,
  input  logic                p_abajo,
  input  logic                p_der,
  input  logic                p_izq,
  input  logic [ANCHO-1:0]    val0_in,
  input  logic [ANCHO-1:0]    val1_in,
  input  logic [ANCHO-1:0]    val2_in,
  output logic [ANCHO-1:0]    campo0,
  output logic [ANCHO-1:0]    campo1,
  output logic [ANCHO-1:0]    campo2,
  output logic [CURSOR_W-1:0] cursor,
  output logic                editando,
  output logic                escribir
);

  estado_t estado, estado_sig;
  accion_t accion;
  logic    timeout;
  logic    cargar;
  logic    en_edit;

  assign en_edit  = (estado == EDIT);
  assign cargar   = (estado == IDLE) && p_enter;
  assign editando = en_edit;
  assign escribir = (estado == COMMIT);

  // Priority encoder: enter > arriba > abajo > der > izq.
  always_comb begin
    accion = NOP;
    if (p_enter)       accion = ENT;
    else if (p_arriba) accion = INC;
    else if (p_abajo)  accion = DEC;
    else if (p_der)    accion = DER;
    else if (p_izq)    accion = IZQ;
  end

  always_ff @(posedge CLK) begin
    if (reset) estado <= IDLE;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      IDLE:    if (p_enter) estado_sig = EDIT;
      EDIT: begin
        if (accion == ENT) estado_sig = COMMIT;
        else if (timeout)  estado_sig = IDLE;
      end
      COMMIT:  estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset || cargar) begin
      cursor <= '0;
    end else if (en_edit && accion == DER) begin
      cursor <= (cursor >= CURSOR_MAX) ? '0 : cursor + 2'd1;
    end else if (en_edit && accion == IZQ) begin
      cursor <= (cursor == '0) ? CURSOR_MAX : cursor - 2'd1;
    end
  end

`ifdef EDITOR_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt;
  logic              algun_pulso;

  assign algun_pulso = p_enter | p_arriba | p_abajo | p_der | p_izq;

  // Counts consecutive pulse-free EDIT cycles; the TIMEOUT-th one aborts.
  always_ff @(posedge CLK) begin
    if (reset || !en_edit || algun_pulso) idle_cnt <= '0;
    else                                  idle_cnt <= idle_cnt + IDLE_W'(1);
  end

  assign timeout = en_edit && !algun_pulso && (idle_cnt == IDLE_W'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  logic step_inc, step_dec;
  assign step_inc = en_edit && (accion == INC);
  assign step_dec = en_edit && (accion == DEC);

  contador_mod #(.ANCHO(ANCHO), .MAX(MAX0)) u_campo0 (
    .CLK(CLK), .reset(reset), .clr(timeout), .load(cargar), .din(val0_in),
    .inc(step_inc && cursor == 2'd0), .dec(step_dec && cursor == 2'd0), .q(campo0)
  );

  contador_mod #(.ANCHO(ANCHO), .MAX(MAX1)) u_campo1 (
    .CLK(CLK), .reset(reset), .clr(timeout), .load(cargar), .din(val1_in),
    .inc(step_inc && cursor == 2'd1), .dec(step_dec && cursor == 2'd1), .q(campo1)
  );

  contador_mod #(.ANCHO(ANCHO), .MAX(MAX2)) u_campo2 (
    .CLK(CLK), .reset(reset), .clr(timeout), .load(cargar), .din(val2_in),
    .inc(step_inc && cursor == 2'd2), .dec(step_dec && cursor == 2'd2), .q(campo2)
  );

endmodule

// File: tb/tb_editor_campos.sv
// tb/tb_editor_campos.sv - self-checking bench for editor_campos
module tb_editor_campos;

  logic       CLK = 1'b0;
  logic       reset;
  logic       p_enter, p_arriba, p_abajo, p_der, p_izq;
  logic [7:0] val0_in, val1_in, val2_in;
  logic [7:0] campo0, campo1, campo2;
  logic [1:0] cursor;
  logic       editando, escribir;

  always #5 CLK = ~CLK;

  editor_campos dut (
    .CLK(CLK), .reset(reset),
    .p_enter(p_enter), .p_arriba(p_arriba), .p_abajo(p_abajo), .p_der(p_der), .p_izq(p_izq),
    .val0_in(val0_in), .val1_in(val1_in), .val2_in(val2_in),
    .campo0(campo0), .campo1(campo1), .campo2(campo2),
    .cursor(cursor), .editando(editando), .escribir(escribir)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: mode 0=idle, 1=editing, 2=committing.
  int m_mode = 0;
  int m_campo[3] = '{0, 0, 0};
  int m_cur = 0;
  int maxv[3] = '{23, 59, 59};
  bit armed = 0;

  always @(posedge CLK) begin
    if (reset) begin
      m_mode = 0; m_cur = 0; m_campo = '{0, 0, 0};
    end else if (m_mode == 0) begin
      if (p_enter) begin
        m_campo[0] = val0_in; m_campo[1] = val1_in; m_campo[2] = val2_in;
        m_cur = 0; m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (p_enter)       m_mode = 2;
      else if (p_arriba) m_campo[m_cur] = (m_campo[m_cur] == maxv[m_cur]) ? 0 : m_campo[m_cur] + 1;
      else if (p_abajo)  m_campo[m_cur] = (m_campo[m_cur] == 0) ? maxv[m_cur] : m_campo[m_cur] - 1;
      else if (p_der)    m_cur = (m_cur + 1) % 3;
      else if (p_izq)    m_cur = (m_cur + 2) % 3;
    end else begin
      m_mode = 0;
    end
  end

  always @(negedge CLK) begin
    if (armed) begin
      chk("campo0", campo0, m_campo[0]);
      chk("campo1", campo1, m_campo[1]);
      chk("campo2", campo2, m_campo[2]);
      chk("cursor", cursor, m_cur);
      chk("editando", editando, m_mode == 1);
      chk("escribir", escribir, m_mode == 2);
    end
  end

  // p = {enter, arriba, abajo, der, izq}; one-cycle pulse, returns #1 after the edge.
  task automatic pulse(input logic [4:0] p);
    {p_enter, p_arriba, p_abajo, p_der, p_izq} = p;
    @(posedge CLK); #1;
    {p_enter, p_arriba, p_abajo, p_der, p_izq} = 5'b0;
  endtask

  localparam logic [4:0] ENTER = 5'b10000, UP = 5'b01000, DN = 5'b00100,
                         RT = 5'b00010, LT = 5'b00001, NONE = 5'b00000;

  initial begin
    reset = 1'b1;
    {p_enter, p_arriba, p_abajo, p_der, p_izq} = 5'b0;
    val0_in = 8'd5; val1_in = 8'd0; val2_in = 8'd0;
    @(posedge CLK); #1;
    armed = 1;
    @(posedge CLK); #1;
    reset = 1'b0;
    chk("reset_editando", editando, 0);
    chk("reset_campo0", campo0, 0);

    // 1: reset mid-EDIT with campo0=5
    pulse(UP);                            // ignored in IDLE
    chk("idle_ignores_arriba", campo0, 0);
    pulse(ENTER);
    chk("load_campo0_5", campo0, 5);
    reset = 1'b1;
    pulse(NONE);
    reset = 1'b0;
    chk("rst_campo0", campo0, 0);
    chk("rst_editando", editando, 0);
    chk("rst_escribir", escribir, 0);
    pulse(NONE);
    chk("rst_no_strobe", escribir, 0);

    // 2: load (12,30,45)
    val0_in = 8'd12; val1_in = 8'd30; val2_in = 8'd45;
    pulse(ENTER);
    chk("load_c0", campo0, 12);
    chk("load_c1", campo1, 30);
    chk("load_c2", campo2, 45);
    chk("load_cursor", cursor, 0);
    chk("load_editando", editando, 1);
    pulse(ENTER);
    pulse(NONE);

    // 3: wrap limits
    val0_in = 8'd23; val1_in = 8'd0; val2_in = 8'd45;
    pulse(ENTER);
    pulse(UP);
    chk("c0_23_up_wraps", campo0, 0);
    pulse(RT);
    pulse(DN);
    chk("c1_0_dn_wraps", campo1, 59);
    pulse(LT); pulse(LT);
    chk("cursor0_izq", cursor, 2);
    pulse(RT);
    chk("cursor2_der", cursor, 0);
    pulse(LT); pulse(UP);                 // campo2 45 -> 46
    chk("c2_up", campo2, 46);
    pulse(DN | RT);                       // abajo beats der
    chk("dn_over_der_c2", campo2, 45);
    chk("dn_over_der_cur", cursor, 2);
    pulse(RT);

    // 4: arriba and der together
    pulse(UP); pulse(UP); pulse(UP);
    chk("c0_is_3", campo0, 3);
    pulse(UP | RT);
    chk("up_der_c0", campo0, 4);
    chk("up_der_cursor", cursor, 0);

    // 5: commit, enter beats arriba, pulses during COMMIT ignored
    pulse(ENTER | UP);
    chk("commit_strobe", escribir, 1);
    chk("commit_c0", campo0, 4);
    chk("commit_c1", campo1, 59);
    chk("commit_c2", campo2, 45);
    pulse(UP);
    chk("strobe_one_cycle", escribir, 0);
    chk("after_commit_editando", editando, 0);
    chk("hold_c0", campo0, 4);
    pulse(NONE);

    // 6: no timeout in the default build
    val0_in = 8'd1; val1_in = 8'd2; val2_in = 8'd3;
    pulse(ENTER);
    for (int i = 0; i < 10000; i++) @(posedge CLK);
    #1;
    chk("still_edit_10000", editando, 1);
    chk("no_strobe_10000", escribir, 0);
    reset = 1'b1;
    pulse(NONE);
    reset = 1'b0;
    chk("final_reset", editando, 0);
    pulse(NONE);

    armed = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
